// File: rtl/apb_uart_rx_fifo.sv
// APB-slave UART receiver with parametrised receive FIFO, optional parity,
// 5-8 bit frames and a 16-bit programmable bit period.
module apb_uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [2:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pslverr
);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BP_W  = 16;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic            sync1_q, sync1_d, line_q, line_d, line_prev_q, line_prev_d;
    state_e          state_q, state_d;
    logic [BP_W-1:0] cnt_q, cnt_d, frame_bp_q, frame_bp_d, bit_period_q, bit_period_d;
    logic [3:0]      frame_size_q, frame_size_d, data_size_q, data_size_d;
    logic [1:0]      frame_par_q, frame_par_d, parity_mode_q, parity_mode_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d, done_data_q, done_data_d;
    logic            par_bit_q, par_bit_d;
    logic            done_q, done_d, done_ok_q, done_ok_d;
    logic            done_ferr_q, done_ferr_d, done_perr_q, done_perr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            err_framing_q, err_framing_d, err_parity_q, err_parity_d;
    logic            err_overrun_q, err_overrun_d;

    logic            fifo_empty, fifo_full, rd_acc, wr_acc, wr_err, pop, push_req, push_ok;
    logic            err_clear, sample_now, par_mismatch;
    logic [BP_W-1:0] bp_eff;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_acc     = psel & penable & ~pwrite;
    assign wr_acc     = psel & penable & pwrite;
    assign pop        = rd_acc & (paddr == 3'd6) & ~fifo_empty;
    assign err_clear  = rd_acc & (paddr == 3'd1);
    assign push_req   = done_q & done_ok_q;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign bp_eff     = (bit_period_q < BP_W'(2)) ? BP_W'(2) : bit_period_q;
    assign sample_now = (cnt_q == '0);
    assign par_mismatch = ((^shreg_q) ^ par_bit_q) != (frame_par_q == 2'd2);

    // Write legality; asserted in both setup and access phases
    always_comb begin
        wr_err = 1'b0;
        if (psel && pwrite) begin
            case (paddr)
                3'd0, 3'd1, 3'd6, 3'd7: wr_err = 1'b1;
                3'd4:    wr_err = (pwdata < 8'd5) || (pwdata > 8'd8);
                3'd5:    wr_err = (pwdata[1:0] == 2'd3);
                default: wr_err = 1'b0;
            endcase
        end
    end

    // Combinational read mux and error response
    always_comb begin
        prdata  = 8'h00;
        pslverr = wr_err;
        if (psel) begin
            case (paddr)
                3'd0: prdata = {6'b0, fifo_full, ~fifo_empty};
                3'd1: prdata = {5'b0, err_parity_q, err_overrun_q, err_framing_q};
                3'd2: prdata = bit_period_q[7:0];
                3'd3: prdata = bit_period_q[15:8];
                3'd4: prdata = {4'b0, data_size_q};
                3'd5: prdata = {6'b0, parity_mode_q};
                3'd6: prdata = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
                default: prdata = 8'(count_q);
            endcase
        end
    end

    // Next-state: config registers, receive FSM, FIFO and sticky errors
    always_comb begin
        sync1_d       = serial_in;
        line_d        = sync1_q;
        line_prev_d   = line_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_bp_d    = frame_bp_q;
        frame_size_d  = frame_size_q;
        frame_par_d   = frame_par_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        par_bit_d     = par_bit_q;
        done_d        = 1'b0;
        done_ok_d     = 1'b0;
        done_ferr_d   = 1'b0;
        done_perr_d   = 1'b0;
        done_data_d   = done_data_q;
        bit_period_d  = bit_period_q;
        data_size_d   = data_size_q;
        parity_mode_d = parity_mode_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (wr_acc && !wr_err) begin
            case (paddr)
                3'd2:    bit_period_d[7:0]  = pwdata;
                3'd3:    bit_period_d[15:8] = pwdata;
                3'd4:    data_size_d        = pwdata[3:0];
                3'd5:    parity_mode_d      = pwdata[1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (line_prev_q && !line_q) begin
                    state_d      = ST_START;
                    frame_bp_d   = bp_eff;
                    frame_size_d = data_size_q;
                    frame_par_d  = parity_mode_q;
                    cnt_d        = (bp_eff >> 1) - BP_W'(1);
                    bit_idx_d    = 3'd0;
                    shreg_d      = 8'h00;
                end
            end
            ST_START: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - BP_W'(1);
                end else if (line_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = frame_bp_q - BP_W'(1);
                end
            end
            ST_DATA: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - BP_W'(1);
                end else begin
                    shreg_d[bit_idx_q] = line_q;
                    cnt_d = frame_bp_q - BP_W'(1);
                    if (bit_idx_q == 3'(frame_size_q - 4'd1)) begin
                        state_d = (frame_par_q != 2'd0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - BP_W'(1);
                end else begin
                    par_bit_d = line_q;
                    cnt_d     = frame_bp_q - BP_W'(1);
                    state_d   = ST_STOP;
                end
            end
            default: begin
                if (!sample_now) begin
                    cnt_d = cnt_q - BP_W'(1);
                end else begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    done_data_d = shreg_q;
                    if (!line_q) begin
                        done_ferr_d = 1'b1;
                    end else if ((frame_par_q != 2'd0) && par_mismatch) begin
                        done_perr_d = 1'b1;
                    end else begin
                        done_ok_d = 1'b1;
                    end
                end
            end
        endcase

        if (push_ok) begin
            mem_d[wr_ptr_q] = done_data_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        err_framing_d = (err_framing_q & ~err_clear) | (done_q & done_ferr_q);
        err_parity_d  = (err_parity_q  & ~err_clear) | (done_q & done_perr_q);
        err_overrun_d = (err_overrun_q & ~err_clear) | (push_req & fifo_full & ~pop);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1_q       <= 1'b1;
            line_q        <= 1'b1;
            line_prev_q   <= 1'b1;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            frame_bp_q    <= '0;
            frame_size_q  <= 4'd8;
            frame_par_q   <= 2'd0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'h00;
            par_bit_q     <= 1'b0;
            done_q        <= 1'b0;
            done_ok_q     <= 1'b0;
            done_ferr_q   <= 1'b0;
            done_perr_q   <= 1'b0;
            done_data_q   <= 8'h00;
            bit_period_q  <= BP_W'(10);
            data_size_q   <= 4'd8;
            parity_mode_q <= 2'd0;
            mem_q         <= '{default: 8'h00};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_framing_q <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            line_q        <= line_d;
            line_prev_q   <= line_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_bp_q    <= frame_bp_d;
            frame_size_q  <= frame_size_d;
            frame_par_q   <= frame_par_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            par_bit_q     <= par_bit_d;
            done_q        <= done_d;
            done_ok_q     <= done_ok_d;
            done_ferr_q   <= done_ferr_d;
            done_perr_q   <= done_perr_d;
            done_data_q   <= done_data_d;
            bit_period_q  <= bit_period_d;
            data_size_q   <= data_size_d;
            parity_mode_q <= parity_mode_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            err_framing_q <= err_framing_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
        end
    end
endmodule

// File: tb/tb_apb_uart_rx_fifo.sv
// Self-checking bench for apb_uart_rx_fifo: register table plus UART frame sequences.
module tb_apb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int BP    = 16;

    logic       clk = 1'b0;
    logic       n_rst, serial_in, psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pslverr;

    apb_uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_d;
        logic       exp_e;
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb_q[$];
    int         model_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic apb_rd(input logic [2:0] a, output logic [7:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [2:0] a, input logic [7:0] v,
                          output logic e_setup, output logic e_acc);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
        #1;
        e_setup = pslverr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e_acc = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        logic       e;
        apb_rd(a, d, e);
        chk(name, int'(d), int'(exp));
    endtask

    task automatic wr_cfg(input logic [2:0] a, input logic [7:0] v);
        logic es, ea;
        apb_wr(a, v, es, ea);
        chk("cfg_write_err", int'(ea), 0);
    endtask

    // Scoreboard entry for a frame that should reach the FIFO
    task automatic exp_push(input logic [7:0] v);
        if (model_cnt < DEPTH) begin
            sb_q.push_back(v);
            model_cnt++;
        end
    endtask

    task automatic pop_chk(input string name);
        logic [7:0] d, exp;
        logic       e;
        exp = 8'h00;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            model_cnt--;
        end
        apb_rd(3'd6, d, e);
        chk(name, int'(d), int'(exp));
        chk({name, "_err"}, int'(e), 0);
    endtask

    // Drive one UART frame; pmode 0=none 1=even 2=odd
    task automatic send_frame(input logic [7:0] v, input int size, input int pmode,
                              input bit bad_par, input logic stop);
        logic p;
        p = 1'b0;
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < size; i++) begin
            serial_in = v[i];
            p = p ^ v[i];
            repeat (BP) @(negedge clk);
        end
        if (pmode != 0) begin
            if (pmode == 2) p = ~p;
            if (bad_par) p = ~p;
            serial_in = p;
            repeat (BP) @(negedge clk);
        end
        serial_in = stop;
        repeat (BP) @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       e, es;

        n_rst = 1'b0; serial_in = 1'b1; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 3'd0; pwdata = 8'h00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        tbl.push_back('{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, "rst_status"});
        tbl.push_back('{1'b0, 3'd1, 8'h00, 8'h00, 1'b0, "rst_errors"});
        tbl.push_back('{1'b0, 3'd2, 8'h00, 8'h0A, 1'b0, "rst_bp_lo"});
        tbl.push_back('{1'b0, 3'd3, 8'h00, 8'h00, 1'b0, "rst_bp_hi"});
        tbl.push_back('{1'b0, 3'd4, 8'h00, 8'h08, 1'b0, "rst_size"});
        tbl.push_back('{1'b0, 3'd5, 8'h00, 8'h00, 1'b0, "rst_parity"});
        tbl.push_back('{1'b0, 3'd7, 8'h00, 8'h00, 1'b0, "rst_count"});
        tbl.push_back('{1'b0, 3'd6, 8'h00, 8'h00, 1'b0, "empty_rx_read"});
        tbl.push_back('{1'b1, 3'd6, 8'h11, 8'h00, 1'b1, "wr_rx_data"});
        tbl.push_back('{1'b1, 3'd4, 8'h09, 8'h00, 1'b1, "wr_size9"});
        tbl.push_back('{1'b0, 3'd4, 8'h00, 8'h08, 1'b0, "size_kept"});
        tbl.push_back('{1'b1, 3'd4, 8'h04, 8'h00, 1'b1, "wr_size4"});
        tbl.push_back('{1'b1, 3'd5, 8'h03, 8'h00, 1'b1, "wr_parity3"});
        tbl.push_back('{1'b0, 3'd5, 8'h00, 8'h00, 1'b0, "parity_kept"});
        tbl.push_back('{1'b1, 3'd0, 8'hFF, 8'h00, 1'b1, "wr_status"});
        tbl.push_back('{1'b1, 3'd7, 8'h01, 8'h00, 1'b1, "wr_count"});
        tbl.push_back('{1'b1, 3'd2, 8'h10, 8'h00, 1'b0, "wr_bp_lo"});
        tbl.push_back('{1'b1, 3'd3, 8'h00, 8'h00, 1'b0, "wr_bp_hi"});
        tbl.push_back('{1'b0, 3'd2, 8'h00, 8'h10, 1'b0, "bp_lo_rb"});
        tbl.push_back('{1'b1, 3'd5, 8'h02, 8'h00, 1'b0, "wr_parity2"});
        tbl.push_back('{1'b0, 3'd5, 8'h00, 8'h02, 1'b0, "parity_rb"});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 8'h00, 1'b0, "wr_parity0"});
        tbl.push_back('{1'b1, 3'd4, 8'h05, 8'h00, 1'b0, "wr_size5"});
        tbl.push_back('{1'b0, 3'd4, 8'h00, 8'h05, 1'b0, "size_rb"});
        tbl.push_back('{1'b1, 3'd4, 8'h08, 8'h00, 1'b0, "wr_size8"});

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                apb_wr(tbl[i].addr, tbl[i].wdata, es, e);
                chk({tbl[i].name, "_setup_err"}, int'(es), int'(tbl[i].exp_e));
                chk({tbl[i].name, "_acc_err"}, int'(e), int'(tbl[i].exp_e));
            end else begin
                apb_rd(tbl[i].addr, d, e);
                chk(tbl[i].name, int'(d), int'(tbl[i].exp_d));
                chk({tbl[i].name, "_err"}, int'(e), int'(tbl[i].exp_e));
            end
        end

        // Outputs are quiet while not selected
        @(negedge clk);
        paddr = 3'd2;
        #1;
        chk("idle_prdata", int'(prdata), 0);
        chk("idle_pslverr", int'(pslverr), 0);

        // Basic 8N1 receive
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1);
        exp_push(8'hA5);
        rd_chk(3'd0, 8'h01, "basic_nonempty");
        pop_chk("basic_data");
        rd_chk(3'd0, 8'h00, "basic_empty");

        // 7-bit even parity, good then bad parity
        wr_cfg(3'd4, 8'd7);
        wr_cfg(3'd5, 8'd1);
        send_frame(8'h55, 7, 1, 1'b0, 1'b1);
        exp_push(8'h55);
        pop_chk("par_good_data");
        send_frame(8'h55, 7, 1, 1'b1, 1'b1);
        rd_chk(3'd1, 8'h04, "par_err_flag");
        rd_chk(3'd7, 8'h00, "par_err_count");
        rd_chk(3'd1, 8'h00, "par_err_cleared");

        // Framing error and a short start glitch
        wr_cfg(3'd4, 8'd8);
        wr_cfg(3'd5, 8'd0);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b0);
        rd_chk(3'd1, 8'h01, "frm_err_flag");
        rd_chk(3'd7, 8'h00, "frm_err_count");
        rd_chk(3'd1, 8'h00, "frm_err_cleared");
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BP / 4) @(negedge clk);
        serial_in = 1'b1;
        repeat (3 * BP) @(negedge clk);
        rd_chk(3'd1, 8'h00, "glitch_no_flag");
        rd_chk(3'd7, 8'h00, "glitch_no_push");
        send_frame(8'h3C, 8, 0, 1'b0, 1'b1);
        exp_push(8'h3C);
        pop_chk("after_glitch_data");

        // Fill past capacity: ninth frame overruns
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 8, 0, 1'b0, 1'b1);
            exp_push(8'(i));
        end
        rd_chk(3'd0, 8'h03, "full_status");
        rd_chk(3'd7, 8'(DEPTH), "full_count");
        rd_chk(3'd1, 8'h02, "overrun_flag");
        for (int i = 0; i < DEPTH; i++) begin
            pop_chk($sformatf("fifo_order_%0d", i));
        end
        rd_chk(3'd7, 8'h00, "drained_count");
        pop_chk("drained_empty_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_uart_rx_fifo.md
Name: apb_uart_rx_fifo

Overview:
APB-slave UART receiver, next generation of the single-buffer APB receiver. Adds a parametrised receive FIFO, optional parity checking, a 5-8 bit frame size and a 16-bit programmable bit period. Sits on the peripheral APB bus and exposes received bytes, status and sticky error flags through an 8-register map.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries (power of 2, 2..64)
PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
serial_in  in  1  asynchronous UART line, idle high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  APB write
paddr  in  3  register address
pwdata  in  8  write data
prdata  out  8  read data
pslverr  out  1  APB error response

Behaviour:
- Reset: one clock, synchronous active-low; sampled on rising clk edge. On n_rst=0 at an edge:
  - FIFO empties; error flags clear.
  - bit_period=10, data_size=8, parity_mode=0.
  - Receive FSM goes to IDLE; synchroniser loads 1.
  - Reset mid-frame discards the partial frame.
- Outputs: prdata and pslverr are combinational and are 0 whenever psel=0.
- Register map (paddr):
  - 0: status (RO) {6'b0, fifo_full, !fifo_empty}.
  - 1: errors (RO) {5'b0, parity_err, overrun_err, framing_err}.
  - 2: bit_period[7:0] (RW).
  - 3: bit_period[15:8] (RW).
  - 4: data_size (RW); only 5..8 legal.
  - 5: parity_mode (RW, bits[1:0]); 0=none, 1=even, 2=odd, 3 illegal.
  - 6: rx_data (RO), FIFO head, right-justified, upper bits 0.
  - 7: fifo_count (RO), 0..FIFO_DEPTH.
- APB: zero wait states. Writes commit in the access phase (psel&penable&pwrite).
- pslverr=1 during both the setup and access phase for:
  - a write to a RO address (0,1,6,7);
  - data_size not in 5..8;
  - parity_mode=3.
  Rejected writes change nothing.
- FIFO pop: on the access-phase read of address 6 when non-empty. Reading an empty FIFO returns 0, no pop, no pslverr.
- Error clear: the access-phase read of address 1 clears all error flags. A set event in the same cycle wins, so that flag stays 1.
- Input sync: 2-flop synchroniser on serial_in. Start detect is a 1->0 transition of the synchronised line while IDLE.
- Bit period: bit_period values <2 behave as 2. The bit counter is 16-bit.
- FSM IDLE -> START: wait bit_period/2 (floor) cycles, then sample. If the line is 1 it is a false start: return to IDLE, no flag.
- FSM START -> DATA: sample every bit_period cycles, data_size bits, LSB first.
- FSM DATA -> PARITY: only if parity_mode≠0. One sample; the even/odd check covers the data bits only.
- FSM DATA/PARITY -> STOP: one sample. Then:
  - stop=0: set framing_err, discard frame.
  - else parity mismatch: set parity_err, discard.
  - else push to FIFO.
  FSM returns to IDLE the cycle after the stop sample; back-to-back frames are supported.
- Push timing: the push occurs 1 cycle after the stop sample.
- Full FIFO: push while full with no same-cycle pop drops the new frame and sets overrun_err; FIFO contents are unchanged. Push and pop in the same cycle on a full FIFO is accepted and the count is unchanged.
- Config changes mid-frame: data_size, parity_mode and bit_period are latched at start detect. Register writes during a frame take effect from the next frame.
- Latching: data_size, parity_mode and bit_period are latched into internal frame-config registers at start detect.

Test Plan:
- Reset state: reads return addr0=0x00, addr1=0x00, addr2=0x0A, addr4=0x08, addr7=0x00.
- Basic receive: bit_period=16, 8N1; send 0xA5, then read addr6 -> 0xA5, and addr0 bit0 goes 1 then 0 after the read.
- 7-bit even parity: send 0x55 with a correct parity bit -> read 0x55. Send it again with a wrong parity bit -> addr1=0x04, FIFO count unchanged. Reading addr1 again -> 0x00.
- FIFO fill: FIFO_DEPTH=8; send 9 frames 0x01..0x09 with no reads:
  - addr0=0x03, addr7=8, addr1=0x02;
  - reads return 0x01..0x08 in order.
- Framing error: stop bit held 0 -> addr1=0x01, no push. A 1/4-bit low glitch -> no flag, FSM stays IDLE.
- APB errors: write addr6 -> pslverr=1; write data_size=9 -> pslverr=1 and it stays 8; write parity_mode=3 -> pslverr=1; a read of empty addr6 -> 0x00 with pslverr=0.
